vga_fb_arbiter: RTL and testbench

- Shares one single-port framebuffer RAM between two users: the VGA display read path and a pixel-drawing client.
- The display read path is driven by pixel_x, pixel_y and video_on from the 640x480 timing generator.
- The framebuffer is 160x120 cells, each 4x4 screen pixels, 4-bit colour.
- Display reads always win. Client writes are buffered in a small FIFO and retired in the free RAM slots. A clear engine fills the whole buffer with one colour.

---
 rtl/vga_fb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display reads win every slot, buffered client
// writes and a whole-buffer clear engine retire in the remaining slots.
module vga_fb_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int COLOR_W    = 4,
    parameter int ADDR_W     = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               video_on,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [7:0]         wr_x,
    input  logic [6:0]         wr_y,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_busy,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [COLOR_W-1:0] ram_wdata,
    input  logic [COLOR_W-1:0] ram_rdata,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_on,
    output logic               drop_pulse
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

    typedef enum logic {NORMAL, CLEAR} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } entry_t;

    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [ADDR_W-1:0] x,
        input logic [ADDR_W-1:0] y
    );
        return y * ADDR_W'(FB_W) + x;
    endfunction

    state_t             state, state_next;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [COLOR_W-1:0] clr_color;

    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PW:0]        wp, rp;
    entry_t             head, entry_in;
    logic               empty, full;
    logic               accept, in_range, push, pop, flush;

    logic               disp_slot, clr_adv, clr_last;
    logic [ADDR_W-1:0]  disp_addr;
    logic               rd_q;
    logic [COLOR_W-1:0] col_q;
    logic [1:0]         von_q;

    // FIFO status and client handshake
    assign empty    = (wp == rp);
    assign full     = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign head     = fifo_mem[rp[PW-1:0]];
    assign wr_ready = !reset && !full && (state == NORMAL);
    assign accept   = wr_valid && wr_ready;
    assign in_range = (32'(wr_x) < 32'(FB_W)) && (32'(wr_y) < 32'(FB_H));
    assign push     = accept && in_range;
    assign flush    = (state == NORMAL) && clear_req;
    assign entry_in = '{addr: cell_addr(ADDR_W'(wr_x), ADDR_W'(wr_y)),
                        color: wr_color};

    assign disp_slot = !reset && video_on
                     && (pixel_x[SCALE_LOG2-1:0] == '0);
    assign disp_addr = cell_addr(ADDR_W'(pixel_x >> SCALE_LOG2),
                                 ADDR_W'(pixel_y >> SCALE_LOG2));

    // Slot decision: display, then clear, then FIFO, else idle
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        pop       = 1'b0;
        clr_adv   = 1'b0;
        if (disp_slot) begin
            ram_addr = disp_addr;
        end else if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt;
            ram_wdata = clr_color;
            clr_adv   = 1'b1;
        end else if (!empty) begin
            ram_we    = 1'b1;
            ram_addr  = head.addr;
            ram_wdata = head.color;
            pop       = 1'b1;
        end
    end

    assign clr_last = clr_adv && (clr_cnt == LAST_ADDR);

    always_comb begin
        state_next = state;
        unique case (state)
            NORMAL: if (clear_req) state_next = CLEAR;
            CLEAR:  if (clr_last)  state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= NORMAL;
            clr_cnt   <= '0;
            clr_color <= '0;
        end else begin
            state <= state_next;
            if (flush) begin
                clr_cnt   <= '0;
                clr_color <= clear_color;
            end else if (clr_last) begin
                clr_cnt <= '0;
            end else if (clr_adv) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Writes accepted in the clear_req cycle are flushed with the rest
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) fifo_mem[wp[PW-1:0]] <= entry_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_pulse <= 1'b0;
            rd_q       <= 1'b0;
            col_q      <= '0;
            von_q      <= '0;
        end else begin
            drop_pulse <= accept && !in_range;
            rd_q       <= disp_slot;
            if (rd_q) col_q <= ram_rdata;
            von_q <= {von_q[0], video_on};
        end
    end

    assign pix_on     = von_q[1];
    assign pix_color  = pix_on ? col_q : '0;
    assign clear_busy = (state == CLEAR);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter against a queue-based slot model
// and a behavioural framebuffer RAM.
module tb_vga_fb_arbiter;

    localparam int NCELL = 19200;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [3:0]  wr_color;
    logic        clear_req;
    logic [3:0]  clear_color;
    logic        clear_busy;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_wdata;
    logic [3:0]  ram_rdata;
    logic [3:0]  pix_color;
    logic        pix_on;
    logic        drop_pulse;

    vga_fb_arbiter dut (
        .clk(clk), .reset(reset),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .clear_req(clear_req), .clear_color(clear_color),
        .clear_busy(clear_busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .pix_color(pix_color), .pix_on(pix_on), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, read data one cycle after the address
    logic [3:0] ram [NCELL];
    always @(posedge clk) begin
        if (int'(ram_addr) < NCELL) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end else begin
            ram_rdata <= 4'h0;
        end
    end

    typedef struct {
        int addr;
        int color;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   n_wr   = 0;

    wr_t  q [$];
    int   ref_mem [NCELL];
    bit   m_clear;
    int   m_cnt, m_color;
    bit   m_drop;
    bit   rd_v;
    int   rd_c, hold;
    bit   von1, von2;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return
    // just after the next rising edge so the caller can drive new inputs.
    task automatic cycle();
        bit disp, ew, pop, acc, inr, was_clear, e_ready;
        int ea, ed;
        @(negedge clk);
        if (reset) begin
            check("rst_addr", 32'(ram_addr), 0);
            check("rst_we", 32'(ram_we), 0);
            check("rst_wdata", 32'(ram_wdata), 0);
            check("rst_pix", 32'(pix_color), 0);
            check("rst_pix_on", 32'(pix_on), 0);
            check("rst_drop", 32'(drop_pulse), 0);
            check("rst_busy", 32'(clear_busy), 0);
            check("rst_ready", 32'(wr_ready), 0);
            q.delete();
            m_clear = 0; m_cnt = 0; m_drop = 0;
            rd_v = 0; rd_c = 0; hold = 0; von1 = 0; von2 = 0;
        end else begin
            e_ready = !m_clear && (q.size() < 4);
            check("pix_on", 32'(pix_on), 32'(von2));
            check("pix_color", 32'(pix_color), von2 ? hold : 0);
            check("clear_busy", 32'(clear_busy), 32'(m_clear));
            check("drop_pulse", 32'(drop_pulse), 32'(m_drop));
            check("wr_ready", 32'(wr_ready), 32'(e_ready));
            disp = video_on && (int'(pixel_x) % 4 == 0);
            ew = 0; pop = 0; ea = 0; ed = 0;
            if (disp) begin
                ea = (int'(pixel_y) / 4) * 160 + int'(pixel_x) / 4;
            end else if (m_clear) begin
                ew = 1; ea = m_cnt; ed = m_color;
            end else if (q.size() > 0) begin
                ew = 1; ea = q[0].addr; ed = q[0].color; pop = 1;
            end
            check("ram_we", 32'(ram_we), 32'(ew));
            check("ram_addr", 32'(ram_addr), ea);
            check("ram_wdata", 32'(ram_wdata), ed);
            if (ram_we === 1'b1) n_wr++;

            hold = rd_v ? rd_c : hold;
            rd_v = disp;
            rd_c = disp ? ref_mem[ea] : 0;
            von2 = von1;
            von1 = video_on;
            if (ew) ref_mem[ea] = ed;
            if (pop) void'(q.pop_front());
            was_clear = m_clear;
            if (m_clear && !disp) begin
                if (m_cnt == NCELL - 1) begin
                    m_clear = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            acc = wr_valid && e_ready;
            inr = (int'(wr_x) < 160) && (int'(wr_y) < 120);
            m_drop = acc && !inr;
            if (acc && inr)
                q.push_back('{int'(wr_y) * 160 + int'(wr_x), int'(wr_color)});
            if (!was_clear && clear_req) begin
                m_clear = 1; m_cnt = 0; m_color = int'(clear_color);
                q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_pix();
        video_on = 1'($urandom_range(0, 1));
        if (video_on) begin
            pixel_x = 10'($urandom_range(0, 639));
            pixel_y = 10'($urandom_range(0, 479));
        end else begin
            pixel_x = 10'($urandom_range(0, 799));
            pixel_y = 10'($urandom_range(0, 524));
        end
    endtask

    task automatic rand_wr();
        wr_valid = 1'($urandom_range(0, 1));
        wr_color = 4'($urandom);
        if ($urandom_range(0, 9) == 0) begin
            wr_x = 8'($urandom_range(160, 255));
            wr_y = 7'($urandom_range(0, 127));
        end else begin
            wr_x = 8'($urandom_range(0, 159));
            wr_y = 7'($urandom_range(0, 119));
        end
    endtask

    task automatic run_clear(input logic [3:0] col, input bit toggle);
        int n0, bad;
        clear_req   = 1'b1;
        clear_color = col;
        cycle();
        clear_req = 1'b0;
        wr_valid  = 1'b0;
        video_on  = 1'b0;
        n0 = n_wr;
        for (int i = 0; i < 40000 && clear_busy !== 1'b0; i++) begin
            if (toggle) rand_pix();
            cycle();
        end
        check("clr_done", 32'(clear_busy), 0);
        check("clr_writes", n_wr - n0, NCELL);
        bad = 0;
        for (int i = 0; i < NCELL; i++)
            if (ram[i] !== col) bad++;
        check("clr_mem", bad, 0);
    endtask

    initial begin
        int n0;
        reset = 1'b1;
        pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
        clear_req = 1'b0; clear_color = '0;
        for (int i = 0; i < NCELL; i++) begin
            ram[i]     = 4'($urandom);
            ref_mem[i] = int'(ram[i]);
        end
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        check("ready_after_rst", 32'(wr_ready), 1);
        check("busy_after_rst", 32'(clear_busy), 0);

        // Reset in the middle of traffic
        for (int i = 0; i < 40; i++) begin
            rand_pix(); rand_wr(); cycle();
        end
        reset = 1'b1;
        #1;
        check("rst_async_we", 32'(ram_we), 0);
        cycle();
        cycle();
        reset = 1'b0;
        wr_valid = 1'b0;
        video_on = 1'b0;
        cycle();
        check("ready_post_rst", 32'(wr_ready), 1);

        // Display read at cell (2,1)
        ram[162] = 4'hA;
        ref_mem[162] = 10;
        video_on = 1'b1; pixel_x = 10'd8; pixel_y = 10'd4;
        #1;
        check("disp_addr", 32'(ram_addr), 162);
        check("disp_we", 32'(ram_we), 0);
        cycle();
        for (int px = 9; px <= 11; px++) begin
            pixel_x = 10'(px);
            cycle();
            check("disp_pix", 32'(pix_color), 32'hA);
            check("disp_pix_on", 32'(pix_on), 1);
        end

        // Blanking write retires the cycle after acceptance
        video_on = 1'b0;
        cycle();
        wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd3; wr_color = 4'h7;
        cycle();
        wr_valid = 1'b0;
        #1;
        check("blank_we", 32'(ram_we), 1);
        check("blank_addr", 32'(ram_addr), 485);
        check("blank_wdata", 32'(ram_wdata), 7);
        cycle();

        // Contention: fill the FIFO under continuous display slots
        video_on = 1'b1; pixel_x = '0; pixel_y = 10'd100;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_x = 8'($urandom_range(0, 159));
            wr_y = 7'($urandom_range(0, 119));
            wr_color = 4'($urandom);
            cycle();
        end
        wr_valid = 1'b0;
        #1;
        check("full_ready", 32'(wr_ready), 0);
        n0 = n_wr;
        for (int i = 0; i < 8; i++) begin
            pixel_x = 10'(i + 1);
            cycle();
        end
        check("retired4", n_wr - n0, 4);
        for (int i = 0; i < 24; i++) begin
            pixel_x = 10'(i);
            rand_wr();
            cycle();
        end
        wr_valid = 1'b0;

        // Out-of-range writes
        video_on = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd0;
        cycle();
        check("drop_x", 32'(drop_pulse), 1);
        wr_x = 8'd0; wr_y = 7'd120;
        cycle();
        wr_valid = 1'b0;
        check("drop_y", 32'(drop_pulse), 1);
        cycle();
        check("drop_end", 32'(drop_pulse), 0);
        check("drop_no_we", 32'(ram_we), 0);

        // Clear with two pending writes plus one in the request cycle
        video_on = 1'b1; pixel_x = '0; pixel_y = '0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_x = 8'(10 + i); wr_y = 7'd5; wr_color = 4'hE;
            cycle();
        end
        wr_x = 8'd12;
        run_clear(4'h3, 1'b0);

        // Clear with display traffic interleaved
        run_clear(4'($urandom), 1'b1);

        // Reset aborts a clear
        video_on = 1'b0;
        clear_req = 1'b1; clear_color = 4'h5;
        cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 50; i++) cycle();
        check("busy_mid_clear", 32'(clear_busy), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("abort_busy", 32'(clear_busy), 0);
        check("abort_ready", 32'(wr_ready), 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rand_pix(); rand_wr(); cycle();
        end
        wr_valid = 1'b0;
        video_on = 1'b0;
        for (int i = 0; i < 8; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
